// File: rtl/serial_subtractor_4bit.sv
// Bit-serial two's-complement subtractor: D = A - B - Bin, LSB first, one bit per clock.
// A single full-subtractor cell walks the captured operands under an idle/shift/done FSM.
module serial_subtractor_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic             diff_bit;
  logic             borrow_nxt;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    diff_bit   = a_q[0] ^ b_q[0] ^ br_q;
    borrow_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  // Next-state logic: capture on accepted start, shift one bit per cycle, pulse done.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = borrow_nxt;
        // Difference bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
        res_d = {diff_bit, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          d_d     = res_d;
          bout_d  = borrow_nxt;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; async reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
    end
  end

  // Outputs come straight from flops; ready decodes the state register only.
  always_comb begin
    ready = (state_q == StIdle);
    D     = d_q;
    Bout  = bout_q;
    done  = done_q;
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Directed bench for serial_subtractor_4bit: latency, pulse width, held start, reset abort,
// and an exhaustive sweep of all operand/borrow combinations.
module tb_serial_subtractor_4bit;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         ready;
  logic [W-1:0] D;
  logic         Bout;
  logic         done;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_d = '0;
  logic         last_bout = 1'b0;

  serial_subtractor_4bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .ready (ready),
    .D     (D),
    .Bout  (Bout),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation: start for a single cycle, check latency, result and done width.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input string tag);
    logic [W:0] exp;
    int lat;
    exp = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    @(negedge clk);
    check({tag, " ready before start"}, ready, 1);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
    check({tag, " ready after accept"}, ready, 0);
    check({tag, " D held from previous op"}, D, last_d);
    check({tag, " Bout held from previous op"}, Bout, last_bout);
    lat = 0;
    for (int k = 1; k <= W + 3; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, lat, W);
    check({tag, " D"}, D, exp[W-1:0]);
    check({tag, " Bout"}, Bout, exp[W]);
    last_d = exp[W-1:0];
    last_bout = exp[W];
    @(posedge clk); #1;
    check({tag, " done width"}, done, 0);
    check({tag, " ready after done"}, ready, 1);
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    #1;
    check("reset ready", ready, 1);
    check("reset done", done, 0);
    check("reset D", D, 0);
    check("reset Bout", Bout, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // T1..T3 directed
    run_op(4'd5, 4'd3, 1'b0, "T1 5-3");
    run_op(4'd0, 4'd1, 1'b0, "T2 0-1");
    run_op(4'd15, 4'd15, 1'b1, "T2 15-15-1");
    run_op(4'd0, 4'd0, 1'b1, "T3 0-0-1");
    run_op(4'd15, 4'd0, 1'b0, "T3 15-0");

    // T4: start held high; done every W+2 cycles; mid-SHIFT operand change ignored.
    @(negedge clk);
    A = 4'd9; B = 4'd4; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin A = 4'd1; B = 4'd2; end
      if (c == 5) begin A = 4'd9; B = 4'd4; end
      check($sformatf("T4 done at cycle %0d", c), done, (c == 4 || c == 10 || c == 16));
      if (done) begin
        check($sformatf("T4 D at cycle %0d", c), D, 5);
        check($sformatf("T4 Bout at cycle %0d", c), Bout, 0);
      end
    end
    start = 1'b0;
    c = 0;
    while (!ready && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check("T4 returns to idle", ready, 1);
    last_d = D;
    last_bout = Bout;

    // T5: reset two cycles into an operation aborts it immediately.
    @(negedge clk);
    A = 4'd7; B = 4'd2; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("T5 ready at reset", ready, 1);
    check("T5 D at reset", D, 0);
    check("T5 Bout at reset", Bout, 0);
    check("T5 done at reset", done, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("T5 no done during reset", done, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("T5 no done after release", done, 0);
    end
    last_d = '0;
    last_bout = 1'b0;
    run_op(4'd7, 4'd2, 1'b0, "T5 7-2");

    // T6: exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          run_op(4'(a), 4'(b), 1'(bi), $sformatf("T6 %0d-%0d-%0d", a, b, bi));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
